// File: rtl/game_session_ctrl.sv
// Game-session controller: frame divider, life counter, post-hit immunity,
// pause handling, saturating BCD score and high score.
module game_session_ctrl #(
  parameter int CLK_FREQ      = 100000000,
  parameter int FRAME_RATE    = 3,
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 4,
  parameter int SCORE_DIGITS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button_press,
  input  logic                      pause_switch,
  input  logic                      collision_detected,
  output logic                      frame_tick,
  output logic [2:0]                state,
  output logic [3:0]                lives,
  output logic [MAX_LIVES-1:0]      life_leds,
  output logic                      game_over,
  output logic                      invuln,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] high_score_bcd
);

  localparam int DIV   = CLK_FREQ / FRAME_RATE;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW    = 4 * SCORE_DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       LIVES_MAX = 4'(MAX_LIVES);
  localparam logic [7:0]       INV_LOAD  = 8'(INVULN_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HIT   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              ret_hit_q, ret_hit_d;   // PAUSE returns to HIT when set, else RUN
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [3:0]        lives_q, lives_d;
  logic [7:0]        inv_q, inv_d;
  logic [SW-1:0]     score_q, score_d;
  logic [SW-1:0]     high_q, high_d;
  logic              btn_q, col_q;

  logic              start_edge, hit_edge;
  logic [SCORE_DIGITS:0] carry;
  logic [SW-1:0]     score_inc;
  logic [SW-1:0]     score_bumped;

  assign start_edge = button_press & ~btn_q;
  assign hit_edge   = collision_detected & ~col_q;

  // Free-running frame divider; the tick register mirrors "divider == DIV-1".
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  // Ripple BCD incrementer; carry out of the top digit means all nines.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_bcd
    logic nine;
    assign nine = (score_q[4*gi +: 4] == 4'd9);
    assign score_inc[4*gi +: 4] = !carry[gi] ? score_q[4*gi +: 4] :
                                  (nine ? 4'd0 : score_q[4*gi +: 4] + 4'd1);
    assign carry[gi+1] = carry[gi] & nine;
  end
  assign score_bumped = carry[SCORE_DIGITS] ? score_q : score_inc;

  // Next-state logic for the session FSM and everything it owns.
  always_comb begin
    state_d   = state_q;
    ret_hit_d = ret_hit_q;
    lives_d   = lives_q;
    inv_d     = inv_q;
    score_d   = score_q;
    high_d    = high_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge && !pause_switch) begin
          score_d = '0;
          lives_d = LIVES_MAX;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tick_q) score_d = score_bumped;
        if (hit_edge) begin
          lives_d = lives_q - 4'd1;
          if (lives_q <= 4'd1) begin
            lives_d = 4'd0;
            state_d = S_OVER;
            // Compare against the score including any coincident tick.
            if (score_d > high_q) high_d = score_d;
          end else begin
            inv_d   = INV_LOAD;
            state_d = S_HIT;
          end
        end else if (pause_switch) begin
          ret_hit_d = 1'b0;
          state_d   = S_PAUSE;
        end
      end
      S_HIT: begin
        // The tick is handled first; a pause then saves whichever state results.
        if (tick_q) begin
          score_d = score_bumped;
          inv_d   = inv_q - 8'd1;
          if (inv_q <= 8'd1) begin
            inv_d   = 8'd0;
            state_d = S_RUN;
          end
        end
        if (pause_switch) begin
          ret_hit_d = (state_d == S_HIT);
          state_d   = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!pause_switch) state_d = ret_hit_q ? S_HIT : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ret_hit_q <= 1'b0;
      div_q     <= '0;
      tick_q    <= 1'b0;
      lives_q   <= LIVES_MAX;
      inv_q     <= 8'd0;
      score_q   <= '0;
      high_q    <= '0;
      btn_q     <= 1'b0;
      col_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_hit_q <= ret_hit_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      lives_q   <= lives_d;
      inv_q     <= inv_d;
      score_q   <= score_d;
      high_q    <= high_d;
      btn_q     <= button_press;
      col_q     <= collision_detected;
    end
  end

  // Thermometer decode of the life counter.
  for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_leds
    assign life_leds[gi] = (lives_q > 4'(gi));
  end

  assign frame_tick     = tick_q;
  assign state          = state_q;
  assign lives          = lives_q;
  assign game_over      = (state_q == S_OVER);
  assign invuln         = (state_q == S_HIT) || ((state_q == S_PAUSE) && ret_hit_q);
  assign score_bcd      = score_q;
  assign high_score_bcd = high_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Bench for game_session_ctrl: directed scenarios plus random levels, every
// cycle compared against a cycle-level behavioural model using plain integers.
module tb_game_session_ctrl;

  localparam int CLK_FREQ      = 20;
  localparam int FRAME_RATE    = 2;
  localparam int DIV           = CLK_FREQ / FRAME_RATE;
  localparam int MAX_LIVES     = 3;
  localparam int INVULN_FRAMES = 2;
  localparam int SCORE_DIGITS  = 2;
  localparam int SW            = 4 * SCORE_DIGITS;
  localparam int MAX_SCORE     = 99;

  localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_PAUSE = 3, M_OVER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b0;
  logic                 button_press = 1'b0;
  logic                 pause_switch = 1'b0;
  logic                 collision_detected = 1'b0;
  logic                 frame_tick;
  logic [2:0]           state;
  logic [3:0]           lives;
  logic [MAX_LIVES-1:0] life_leds;
  logic                 game_over;
  logic                 invuln;
  logic [SW-1:0]        score_bcd;
  logic [SW-1:0]        high_score_bcd;

  game_session_ctrl #(
    .CLK_FREQ(CLK_FREQ), .FRAME_RATE(FRAME_RATE), .MAX_LIVES(MAX_LIVES),
    .INVULN_FRAMES(INVULN_FRAMES), .SCORE_DIGITS(SCORE_DIGITS)
  ) dut (
    .clk(clk), .reset(reset), .button_press(button_press),
    .pause_switch(pause_switch), .collision_detected(collision_detected),
    .frame_tick(frame_tick), .state(state), .lives(lives),
    .life_leds(life_leds), .game_over(game_over), .invuln(invuln),
    .score_bcd(score_bcd), .high_score_bcd(high_score_bcd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, integers throughout.
  int m_state, m_lives, m_score, m_high, m_inv, m_ret, m_div;
  bit m_btn, m_col;
  bit m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bump(input int s);
    return (s < MAX_SCORE) ? s + 1 : s;
  endfunction

  // Advance the model across one rising edge given the inputs held before it.
  task automatic model_edge(input bit r, input bit b, input bit p, input bit c);
    bit tick, start, hit;
    if (!r) begin
      m_state = M_IDLE; m_lives = MAX_LIVES; m_score = 0; m_high = 0;
      m_inv = 0; m_ret = M_RUN; m_div = 0; m_btn = 0; m_col = 0;
      m_valid = 1'b1;
      return;
    end
    tick  = (m_div == DIV - 1);
    start = b && !m_btn;
    hit   = c && !m_col;
    m_div = (m_div + 1) % DIV;
    m_btn = b;
    m_col = c;
    case (m_state)
      M_IDLE, M_OVER: begin
        if (start && !p) begin
          m_score = 0; m_lives = MAX_LIVES; m_state = M_RUN;
        end
      end
      M_RUN: begin
        if (tick) m_score = bump(m_score);
        if (hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_state = M_OVER;
            if (m_score > m_high) m_high = m_score;
          end else begin
            m_inv = INVULN_FRAMES; m_state = M_HIT;
          end
        end else if (p) begin
          m_ret = M_RUN; m_state = M_PAUSE;
        end
      end
      M_HIT: begin
        if (tick) begin
          m_score = bump(m_score);
          m_inv = m_inv - 1;
          if (m_inv == 0) m_state = M_RUN;
        end
        if (p) begin
          m_ret = m_state; m_state = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (!p) m_state = m_ret;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    if (!m_valid) return;
    check("frame_tick", 32'(frame_tick), 32'(m_div == DIV - 1));
    check("state", 32'(state), 32'(m_state));
    check("lives", 32'(lives), 32'(m_lives));
    check("life_leds", 32'(life_leds), 32'((1 << m_lives) - 1));
    check("game_over", 32'(game_over), 32'(m_state == M_OVER));
    check("invuln", 32'(invuln), 32'(m_state == M_HIT || (m_state == M_PAUSE && m_ret == M_HIT)));
    check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("high_score", 32'(high_score_bcd), 32'(to_bcd(m_high)));
  endtask

  // One clock: drive on the falling edge, model at the rising edge, sample 1 later.
  task automatic cycle(input bit r, input bit b, input bit p, input bit c);
    @(negedge clk);
    reset = r; button_press = b; pause_switch = p; collision_detected = c;
    @(posedge clk);
    model_edge(r, b, p, c);
    #1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, first_high, saved_score;
    bit rb, rp, rc;

    // Reset and divider period.
    repeat (3) cycle(0, 0, 0, 0);
    check("rst_state", 32'(state), 32'(0));
    check("rst_lives", 32'(lives), 32'(3));
    check("rst_leds", 32'(life_leds), 32'(3'b111));
    check("rst_score", 32'(score_bcd), 32'(8'h00));
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 0, 0);
      if (frame_tick) ticks++;
    end
    check("ticks_in_30", 32'(ticks), 32'(3));

    // Start and count up through the 09 -> 10 carry.
    cycle(1, 1, 0, 0);
    check("start_run", 32'(state), 32'(M_RUN));
    for (int i = 0; i < 300 && m_score < 12; i++) cycle(1, 0, 0, 0);
    check("score_12", 32'(score_bcd), 32'(8'h12));

    // Held collision: one decrement, immunity for exactly two ticks.
    cycle(1, 0, 0, 1);
    check("hit_lives", 32'(lives), 32'(2));
    check("hit_leds", 32'(life_leds), 32'(3'b011));
    ticks = (invuln && frame_tick) ? 1 : 0;
    for (int i = 0; i < 39; i++) begin
      cycle(1, 0, 0, 1);
      if (invuln && frame_tick) ticks++;
    end
    check("invuln_ticks", 32'(ticks), 32'(2));
    check("held_lives", 32'(lives), 32'(2));
    check("held_state", 32'(state), 32'(M_RUN));
    cycle(1, 0, 0, 0);

    // Second hit, pause after one immunity tick.
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 30 && m_inv != 1; i++) cycle(1, 0, 0, 0);
    saved_score = m_score;
    for (int i = 0; i < 50; i++) cycle(1, 0, 1, 0);
    check("pause_state", 32'(state), 32'(M_PAUSE));
    check("pause_score", 32'(score_bcd), 32'(to_bcd(saved_score)));
    check("pause_invuln", 32'(invuln), 32'(1));
    ticks = 0;
    for (int i = 0; i < 30 && state != M_RUN; i++) begin
      if (invuln && frame_tick) ticks++;
      cycle(1, 0, 0, 0);
    end
    check("resume_ticks", 32'(ticks), 32'(1));
    check("resume_run", 32'(state), 32'(M_RUN));

    // Third hit ends the game.
    first_high = m_score;
    cycle(1, 0, 0, 1);
    check("over_flag", 32'(game_over), 32'(1));
    check("over_lives", 32'(lives), 32'(0));
    check("over_high", 32'(high_score_bcd), 32'(to_bcd(first_high)));
    cycle(1, 0, 0, 0);

    // Quick second game with a lower score.
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 1);
      for (int i = 0; i < 40 && m_state == M_HIT; i++) cycle(1, 0, 0, 0);
    end
    check("quick_over", 32'(state), 32'(M_OVER));
    check("high_kept", 32'(high_score_bcd), 32'(to_bcd(first_high)));

    // Start with pause held is ignored.
    cycle(1, 0, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(1, 0, 1, 0);
    check("start_paused", 32'(state), 32'(M_OVER));
    cycle(1, 0, 0, 0);

    // Saturation at 99.
    cycle(1, 1, 0, 0);
    repeat (1100) cycle(1, 0, 0, 0);
    check("score_sat", 32'(score_bcd), 32'(8'h99));

    // Mid-game reset.
    cycle(0, 0, 0, 0);
    check("mid_rst_state", 32'(state), 32'(0));
    check("mid_rst_score", 32'(score_bcd), 32'(0));
    check("mid_rst_high", 32'(high_score_bcd), 32'(0));
    check("mid_rst_tick", 32'(frame_tick), 32'(0));

    // Random level stimulus against the model.
    rb = 0; rp = 0; rc = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) rb = ~rb;
      if ($urandom_range(59) == 0) rp = ~rp;
      if ($urandom_range(7) == 0)  rc = ~rc;
      cycle($urandom_range(699) != 0, rb, rp, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Parametrised game-session controller for the arcade platform.
- Replaces hard-wired 2-bit life decoding, game_over logic and score-enable glue at the top level with a single sequential block.
- Owns the frame tick, life counter, post-hit invulnerability window, pause handling, BCD score and high score.
- Sits between button/switch inputs, the VGA collision output, the score display and the life LEDs.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- FRAME_RATE, 3, frame ticks per second; DIV = CLK_FREQ/FRAME_RATE, and DIV must be at least 2.
- MAX_LIVES, 3, lives at game start; legal range 1..15.
- INVULN_FRAMES, 4, frame ticks of collision immunity after a hit; legal range 1..255.
- SCORE_DIGITS, 4, number of BCD score digits; legal range 1..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- button_press  in  1  start/restart request (level; block edge-detects).
- pause_switch  in  1  pause level.
- collision_detected  in  1  collision level from the VGA controller.
- frame_tick  out  1  one-cycle pulse every DIV clocks.
- state  out  3  IDLE=0, RUN=1, HIT=2, PAUSE=3, OVER=4.
- lives  out  4  remaining lives.
- life_leds  out  MAX_LIVES  thermometer code; bit i is high iff lives > i.
- game_over  out  1  high iff state==OVER.
- invuln  out  1  high iff in HIT, or in PAUSE with the return state HIT.
- score_bcd  out  4*SCORE_DIGITS  current score, digit 0 in the LSBs.
- high_score_bcd  out  4*SCORE_DIGITS  best score since reset.

Behaviour:
- Reset is sampled on a clk edge with reset==0. After reset:
  - state=IDLE, lives=MAX_LIVES, score=0, high_score=0;
  - frame_tick=0, divider=0, invuln counter=0;
  - edge-detect registers = 0.
- The divider free-runs in every state. frame_tick=1 in the cycle the divider equals DIV-1; the divider then wraps to 0.
- Edge detection: start_edge = button_press & ~button_press_d; hit_edge = collision_detected & ~collision_d. The _d registers update every cycle.
- IDLE / OVER:
  - If start_edge and pause_switch==0: score=0, lives=MAX_LIVES, go to RUN next cycle.
  - If start_edge with pause_switch==1: the edge is ignored.
  - collision_detected is ignored in these states.
- RUN, in priority order:
  1. hit_edge: lives decrements. If the new value is 0, go to OVER. Otherwise load the invuln counter with INVULN_FRAMES and go to HIT.
  2. Otherwise, pause_switch==1: go to PAUSE with the return state RUN.
- HIT:
  - Collisions are ignored.
  - Each frame_tick decrements the invuln counter. When the counter reaches 0, return to RUN on the same edge.
  - If pause_switch==1: go to PAUSE with the return state HIT; the counter is frozen.
  - If pause_switch and a frame_tick occur in the same cycle, the tick is processed first, then the pause transition.
- PAUSE:
  - Score, lives and the invuln counter are all frozen.
  - When pause_switch==0, return to the saved state next cycle.
  - The divider keeps running.
- Score:
  - On frame_tick while in RUN or HIT, score increments by 1 in BCD with per-digit carry.
  - The score saturates at all nines; it does not wrap.
  - A frame_tick in the same cycle as a hit_edge in RUN still increments the score.
- High score:
  - On the edge entering OVER, high_score is set to score if score > high_score (unsigned BCD compare, equivalent to a binary compare).
  - The score held in that same cycle, including any coincident tick increment, is used.
- Lives never underflow; lives==0 only occurs in OVER.
- life_leds, game_over and invuln are combinational decodes of registered state.
- All other outputs are registered.
- Reset asserted mid-game behaves identically to power-up reset; high_score is lost.

Test Plan:
- Params CLK_FREQ=20, FRAME_RATE=2 (DIV=10), MAX_LIVES=3, INVULN_FRAMES=2, SCORE_DIGITS=2. Hold reset low 3 cycles, release -> state=0, lives=3, life_leds=3'b111, score=0x00; frame_tick pulses every 10 clocks exactly.
- Pulse button_press, run 12 ticks -> state=RUN, score_bcd=0x12 (BCD carry from 0x09 to 0x10 checked).
- In RUN, raise collision_detected and hold it 40 clocks -> lives=2, life_leds=3'b011, invuln=1 for exactly 2 ticks, then RUN. The held level causes no second decrement; the score keeps counting through HIT.
- In HIT after 1 tick, set pause_switch for 50 clocks -> score and counter frozen, state=3. Release -> HIT resumes and exits after exactly 1 more tick.
- Three separated collisions -> lives=0, game_over=1, high_score_bcd=score. Restart and lose quickly with a lower score -> high_score unchanged. Hold pause_switch=1 while pressing start in OVER -> remains OVER.
- Run 100 ticks without collision -> score saturates at 0x99. Assert reset mid-RUN -> all outputs return to reset values on the next edge.
